// File: rtl/unsigned_adder_acc.sv
// ---------------------------------------------------------------------------
// unsigned_adder_acc
//
// Handshaked WIDTH-bit unsigned adder / accumulator with a single registered
// output stage. Each accepted operation either adds A+B (MODE=0) or adds A
// to an internal running accumulator (MODE=1). The result, its carry-out and
// a sticky overflow flag are registered. Flow control follows valid/ready on
// both the input and the output side.
//
// Optional feature macro: SATURATE_EN
//   defined   -> on carry, SUM (and ACC in MODE=1) load all-ones
//   undefined -> results wrap modulo 2^WIDTH (no saturation logic built)
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   A          in   operand A (unsigned, WIDTH bits)
//   B          in   operand B (unsigned, WIDTH bits), ignored when MODE=1
//   MODE       in   0: A+B, 1: ACC+A
//   CLR        in   synchronous clear of accumulator and sticky overflow
//   IN_VALID   in   A/B/MODE valid
//   IN_READY   out  block can accept an operation this cycle
//   SUM        out  registered result (WIDTH bits)
//   COUT       out  carry-out of the operation that produced SUM
//   OUT_VALID  out  SUM/COUT valid
//   OUT_READY  in   consumer takes SUM this cycle
//   OVF        out  sticky: some accepted operation carried since reset/CLR
// ---------------------------------------------------------------------------
module unsigned_adder_acc #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MODE,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OVF
);

  // Registered state
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // Datapath intermediates
  logic             in_ready;
  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   raw_sum;
  logic             carry;
  logic [WIDTH-1:0] result;

  // Single output register: a new operation can only enter when the slot is
  // empty or is being drained in the same cycle.
  always_comb begin
    in_ready = !out_valid_q || OUT_READY;
    accept   = IN_VALID && in_ready;
    emit     = out_valid_q && OUT_READY;
  end

  // Adder. A same-cycle CLR zeroes the accumulator before it is used, and
  // both operands are zero-extended so the carry is never lost.
  always_comb begin
    acc_eff   = CLR ? '0 : acc_q;
    operand_b = MODE ? acc_eff : B;
    raw_sum   = {1'b0, A} + {1'b0, operand_b};
    carry     = raw_sum[WIDTH];
`ifdef SATURATE_EN
    result    = carry ? {WIDTH{1'b1}} : raw_sum[WIDTH-1:0];
`else
    result    = raw_sum[WIDTH-1:0];
`endif
  end

  // Next-state logic for the output stage, accumulator and overflow flag.
  // With CLR and accept together the flag reflects only this operation.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;

    if (accept) begin
      sum_d       = result;
      cout_d      = carry;
      out_valid_d = 1'b1;
      if (MODE) begin
        acc_d = result;
      end else if (CLR) begin
        acc_d = '0;
      end
      if (CLR) begin
        ovf_d = carry;
      end else begin
        ovf_d = ovf_q | carry;
      end
    end else begin
      if (emit) begin
        out_valid_d = 1'b0;
      end
      if (CLR) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
    end
  end

  // State registers, cleared immediately by the asynchronous reset so any
  // pending result is discarded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign IN_READY  = in_ready;
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_unsigned_adder_acc.sv
// ---------------------------------------------------------------------------
// tb_unsigned_adder_acc
//
// Directed bench for unsigned_adder_acc at WIDTH=8. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_unsigned_adder_acc;

  logic       CLK;
  logic       RST;
  logic [7:0] A;
  logic [7:0] B;
  logic       MODE;
  logic       CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] SUM;
  logic       COUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       OVF;

  int errors = 0;
  int checks = 0;

  unsigned_adder_acc #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .MODE      (MODE),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .SUM       (SUM),
    .COUT      (COUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVF       (OVF)
  );

  // 10-time-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one set of inputs, then advance to the falling edge after the
  // next rising edge where outputs are sampled.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic mode, input logic clr,
                               input logic valid);
    A        = a;
    B        = b;
    MODE     = mode;
    CLR      = clr;
    IN_VALID = valid;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST       = 1'b1;
    A         = '0;
    B         = '0;
    MODE      = 1'b0;
    CLR       = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;

    // Reset state
    #3;
    checkOutput("rst_sum",       32'(SUM),       32'h0);
    checkOutput("rst_cout",      32'(COUT),      32'h0);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'h0);
    checkOutput("rst_ovf",       32'(OVF),       32'h0);
    checkOutput("rst_in_ready",  32'(IN_READY),  32'h1);
    @(negedge CLK);
    RST = 1'b0;

    // Plain add
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    checkOutput("add_sum",       32'(SUM),       32'h46);
    checkOutput("add_cout",      32'(COUT),      32'h0);
    checkOutput("add_out_valid", 32'(OUT_VALID), 32'h1);
    checkOutput("add_ovf",       32'(OVF),       32'h0);

    // Carry with wrap, then sticky overflow
    applyStimulus(8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    checkOutput("carry_sum",  32'(SUM),  32'h10);
    checkOutput("carry_cout", 32'(COUT), 32'h1);
    checkOutput("carry_ovf",  32'(OVF),  32'h1);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    checkOutput("after_sum",  32'(SUM),  32'h02);
    checkOutput("after_cout", 32'(COUT), 32'h0);
    checkOutput("after_ovf",  32'(OVF),  32'h1);

    // Idle: result drains, SUM holds
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_out_valid", 32'(OUT_VALID), 32'h0);
    checkOutput("drain_sum_hold",  32'(SUM),       32'h02);

    // CLR pulse without accept clears OVF, output stage untouched
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_ovf",      32'(OVF), 32'h0);
    checkOutput("clr_sum_hold", 32'(SUM), 32'h02);

    // Accumulate back-to-back
    applyStimulus(8'h50, 8'hAA, 1'b1, 1'b0, 1'b1);
    checkOutput("acc1_sum", 32'(SUM), 32'h50);
    applyStimulus(8'h50, 8'hAA, 1'b1, 1'b0, 1'b1);
    checkOutput("acc2_sum",  32'(SUM),  32'hA0);
    checkOutput("acc2_cout", 32'(COUT), 32'h0);
    applyStimulus(8'h70, 8'hAA, 1'b1, 1'b0, 1'b1);
`ifdef SATURATE_EN
    checkOutput("acc3_sum", 32'(SUM), 32'hFF);
`else
    checkOutput("acc3_sum", 32'(SUM), 32'h10);
`endif
    checkOutput("acc3_cout", 32'(COUT), 32'h1);
    checkOutput("acc3_ovf",  32'(OVF),  32'h1);

    // Backpressure: result 0x46 held while OUT_READY is low
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_first_sum", 32'(SUM), 32'h46);
    OUT_READY = 1'b0;
    A         = 8'h01;
    B         = 8'h02;
    #1;
    checkOutput("bp_in_ready_low", 32'(IN_READY), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("bp_hold_sum_%0d", i),   32'(SUM),       32'h46);
      checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(OUT_VALID), 32'h1);
      checkOutput($sformatf("bp_hold_ready_%0d", i), 32'(IN_READY),  32'h0);
    end
    OUT_READY = 1'b1;
    #1;
    checkOutput("bp_in_ready_high", 32'(IN_READY), 32'h1);
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_new_sum",   32'(SUM),       32'h03);
    checkOutput("bp_new_valid", 32'(OUT_VALID), 32'h1);

    // CLR together with accept: ACC zeroed before use, OVF from this op only
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_ovf", 32'(OVF), 32'h1);
    applyStimulus(8'h80, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("acc80_sum", 32'(SUM), 32'h80);
    applyStimulus(8'h05, 8'h00, 1'b1, 1'b1, 1'b1);
    checkOutput("clracc_sum",  32'(SUM),  32'h05);
    checkOutput("clracc_cout", 32'(COUT), 32'h0);
    checkOutput("clracc_ovf",  32'(OVF),  32'h0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("clracc_acc_readback", 32'(SUM), 32'h05);

    // MODE=0 does not disturb ACC
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    checkOutput("mode0_sum", 32'(SUM), 32'h30);
    applyStimulus(8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("mode0_acc_kept", 32'(SUM), 32'h06);

    // Async reset mid-stream with a pending result and OVF set
    applyStimulus(8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    OUT_READY = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    checkOutput("prerst_valid", 32'(OUT_VALID), 32'h1);
    checkOutput("prerst_ovf",   32'(OVF),       32'h1);
    IN_VALID = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_valid",    32'(OUT_VALID),  32'h0);
    checkOutput("arst_sum",      32'(SUM),        32'h0);
    checkOutput("arst_ovf",      32'(OVF),        32'h0);
    checkOutput("arst_acc",      32'(dut.acc_q),  32'h0);
    checkOutput("arst_in_ready", 32'(IN_READY),   32'h1);
    @(negedge CLK);
    RST       = 1'b0;
    OUT_READY = 1'b1;
    applyStimulus(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
    checkOutput("postrst_sum",   32'(SUM),       32'h07);
    checkOutput("postrst_valid", 32'(OUT_VALID), 32'h1);
    applyStimulus(8'h09, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("postrst_acc", 32'(SUM), 32'h09);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unsigned_adder_acc.md
# unsigned_adder_acc

Parametrised, handshaked unsigned adder/accumulator. It generalises the 8-bit combinational adder to WIDTH bits and adds carry-out, a registered output stage with valid/ready flow control, a running-accumulate mode and a sticky overflow flag. It sits between a producer and a consumer that both use valid/ready streams, for example in datapath sum/accumulate chains.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)

- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A (unsigned)
- B  input  WIDTH  operand B (unsigned); ignored when MODE=1
- MODE  input  1  0 = SUM=A+B; 1 = accumulate ACC+A
- CLR  input  1  synchronous clear of accumulator and sticky overflow
- IN_VALID  input  1  A/B/MODE valid
- IN_READY  output  1  block can accept this cycle
- SUM  output  WIDTH  registered result
- COUT  output  1  carry-out of the operation that produced SUM
- OUT_VALID  output  1  SUM/COUT valid
- OUT_READY  input  1  consumer accepts SUM
- OVF  output  1  sticky: any accepted operation carried since reset/CLR

## Operation
- Accept = IN_VALID && IN_READY. Emit = OUT_VALID && OUT_READY.
- IN_READY = !OUT_VALID || OUT_READY (combinational; single output register, no skid buffer).
- Internal ACC register, WIDTH bits.
- Sum: R[WIDTH:0] = A + (MODE ? ACC_eff : B), with zero-extension to WIDTH+1; no truncation before the add.
- ACC_eff = 0 if CLR is asserted in the same cycle, else ACC.
- On accept:
  - SUM <= R[WIDTH-1:0] (see Configuration); COUT <= R[WIDTH]; OUT_VALID <= 1.
  - If MODE=1: ACC <= value written to SUM.
  - If R[WIDTH]=1: OVF <= 1.
- MODE=0 accepts never modify ACC.
- On emit without accept: OUT_VALID <= 0; SUM/COUT hold their last values.
- While OUT_VALID && !OUT_READY: SUM, COUT and OUT_VALID are frozen; no accept occurs.
- CLR without accept: ACC <= 0, OVF <= 0; output stage is unaffected.
- CLR with accept: ACC is zeroed before use. OVF <= carry of this operation only.

## Timing
- Latency: 1 cycle, accept at edge N gives OUT_VALID=1 after edge N.
- Throughput: 1 operation/cycle when OUT_READY is held high.
- Reset (asynchronous, immediate): SUM=0, COUT=0, OUT_VALID=0, ACC=0, OVF=0. Hence IN_READY=1 during and after reset.
- Reset mid-operation: a pending unconsumed result is discarded. The first accept after RST deasserts is processed normally.
- Simultaneous emit and accept in one cycle: the new result replaces the old one; OUT_VALID stays 1.
- Wrap-around: with SATURATE_EN off, results wrap modulo 2^WIDTH; COUT still reports the carry.

## Configuration
- SATURATE_EN defined: when R[WIDTH]=1, SUM (and ACC in MODE=1) is loaded with all-ones (2^WIDTH−1). COUT and OVF still assert.
- SATURATE_EN undefined: SUM/ACC take R[WIDTH-1:0] (wrapping). No saturation logic is synthesised.

## Test plan
- Reset then add, WIDTH=8, OUT_READY=1:
  - A=0x12, B=0x34, MODE=0 -> next cycle SUM=0x46, COUT=0, OUT_VALID=1, OVF=0.
- Carry, no SATURATE_EN:
  - A=0xF0, B=0x20 -> SUM=0x10, COUT=1, OVF=1.
  - Follow with A=1, B=1 -> SUM=0x02, COUT=0, OVF stays 1.
- Accumulate: CLR pulse, then MODE=1 with A=0x50, 0x50, 0x70 back-to-back:
  - SUMs=0x50, 0xA0, 0x10 (COUT=1 on the third) without SATURATE_EN.
  - SUMs=0x50, 0xA0, 0xFF with SATURATE_EN.
- Backpressure: hold OUT_READY=0 after one result 0x46 -> IN_READY=0, SUM held at 0x46 across 5 cycles with new IN_VALID ignored. Raise OUT_READY -> held value consumed, then the new operand is accepted in the same cycle.
- CLR with accept: ACC=0x80, then CLR=1, MODE=1, A=0x05 -> SUM=0x05, ACC=0x05, OVF=0.
- Async reset mid-stream: assert RST between clock edges while OUT_VALID=1 -> OUT_VALID, SUM, ACC and OVF go to 0 immediately, before the next edge.
